sparse_mult_arbiter: RTL and testbench

//   Shares one sparse-multiply engine (e.g. sparse_mult_by_E) between NUM_REQ requesters.

---
 rtl/sparse_mult_pkg.sv | 28 ++
 rtl/sparse_tag_fifo.sv | 65 ++++++
 rtl/sparse_mult_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sparse_mult_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_mult_pkg.sv
// ---------------------------------------------------------------------------
// sparse_mult_pkg
//   Shared constants and types for the sparse-multiply engine and its
//   requester arbiter.
//   SPARSE_WIDTH / LANE_WIDTH : engine word width and per-lane width
//   E_IN_LEN / E_OUT_LEN      : words in / out per engine frame
//   MAX_REQ / req_idx_t       : largest supported requester count and the
//                               index type stored in the tag FIFO
//   arb_state_t               : arbiter FSM states
// ---------------------------------------------------------------------------
package sparse_mult_pkg;

   localparam int SPARSE_WIDTH = 96;
   localparam int LANE_WIDTH   = 32;
   localparam int E_IN_LEN     = 11;
   localparam int E_OUT_LEN    = 1;

   localparam int MAX_REQ      = 8;
   localparam int REQ_IDX_W    = $clog2(MAX_REQ);

   typedef logic [REQ_IDX_W-1:0] req_idx_t;

   typedef enum logic {
      IDLE,
      STREAM
   } arb_state_t;

endpackage

// File: rtl/sparse_tag_fifo.sv
// ---------------------------------------------------------------------------
// sparse_tag_fifo
//   Synchronous first-word-fall-through FIFO of requester indices. Records
//   the order in which frames were granted so engine results can be steered
//   back to their owners in that same order.
//   i_clock, i_reset : clock, synchronous active-high reset
//   push, push_data  : write a tag (ignored when full)
//   pop              : drop the head tag (ignored when empty)
//   head             : current front tag, valid whenever !empty
//   count            : number of tags held (0..DEPTH)
//   full, empty      : occupancy flags
//   DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module sparse_tag_fifo
   import sparse_mult_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic                         push,
   input  req_idx_t                     push_data,
   input  logic                         pop,
   output req_idx_t                     head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   req_idx_t      mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // NOTE: storage is deliberately left out of reset; the pointers and count
   // decide what is valid, and an unreset array maps onto plain RAM/flops.
   always_ff @(posedge i_clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sparse_mult_arbiter.sv
// ---------------------------------------------------------------------------
// sparse_mult_arbiter
//   Shares one sparse-multiply engine between NUM_REQ requesters. Grants are
//   round-robin and held for a whole IN_LEN-word input frame; a tag FIFO keeps
//   grant order so the OUT_LEN-word results go back to their owners in order.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_req_data/valid, o_req_ready     : requester input streams
//   o_resp_data, o_resp_valid (1-hot), i_resp_ready : result streams
//   o_eng_data/valid, i_eng_ready     : to engine input
//   i_eng_data/valid, o_eng_ready     : from engine output
//   o_grant : current/last granted requester,  o_busy : work in flight
// ---------------------------------------------------------------------------
module sparse_mult_arbiter
   import sparse_mult_pkg::*;
#(
   parameter int WIDTH           = SPARSE_WIDTH,
   parameter int NUM_REQ         = 2,
   parameter int IN_LEN          = E_IN_LEN,
   parameter int OUT_LEN         = E_OUT_LEN,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [NUM_REQ*WIDTH-1:0]     i_req_data,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic [WIDTH-1:0]             o_resp_data,
   output logic [NUM_REQ-1:0]           o_resp_valid,
   input  logic [NUM_REQ-1:0]           i_resp_ready,
   output logic [WIDTH-1:0]             o_eng_data,
   output logic                         o_eng_valid,
   input  logic                         i_eng_ready,
   input  logic [WIDTH-1:0]             i_eng_data,
   input  logic                         i_eng_valid,
   output logic                         o_eng_ready,
   output logic [$clog2(NUM_REQ)-1:0]   o_grant,
   output logic                         o_busy
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(IN_LEN+1);
   localparam int RW = $clog2(OUT_LEN+1);
   localparam int CW = $clog2(MAX_OUTSTANDING+1);
   localparam logic [BW-1:0] IN_LAST  = BW'(IN_LEN-1);
   localparam logic [RW-1:0] OUT_LAST = RW'(OUT_LEN-1);

   arb_state_t    state;
   logic [GW-1:0] grant;
   logic [GW-1:0] rr_ptr;
   logic [BW-1:0] beat_cnt;
   logic [RW-1:0] resp_cnt;

   logic [WIDTH-1:0]   req_word [NUM_REQ];
   logic [NUM_REQ-1:0] head_onehot;
   logic [GW-1:0]      sel_idx;
   logic               sel_found;
   logic               can_start;
   logic               beat;
   logic               resp_hs;
   logic               tag_pop;

   req_idx_t      tag_head;
   logic [CW-1:0] tag_count;
   logic          tag_full;
   logic          tag_empty;

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
      assign req_word[r] = i_req_data[r*WIDTH +: WIDTH];
   end

   // Round-robin search: walk downward from the farthest candidate so the
   // nearest valid requester at or after rr_ptr is the last one written.
   always_comb begin
      int idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (i_req_valid[GW'(idx)]) begin
            sel_found = 1'b1;
            sel_idx   = GW'(idx);
         end
      end
   end

   always_comb begin
      for (int g = 0; g < NUM_REQ; g++) begin
         head_onehot[g] = (tag_head == req_idx_t'(g));
      end
   end

   assign can_start = (state == IDLE) & sel_found & ~tag_full;
   assign beat      = (state == STREAM) & i_req_valid[grant] & i_eng_ready;
   assign resp_hs   = ~tag_empty & i_eng_valid & |(i_resp_ready & head_onehot);
   assign tag_pop   = resp_hs & (resp_cnt == OUT_LAST);

   sparse_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .push      (can_start),
      .push_data (req_idx_t'(sel_idx)),
      .pop       (tag_pop),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   // NOTE: every register here uses <= so all state updates see the values
   // from before the edge, independent of statement order.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (can_start) begin
                  grant    <= sel_idx;
                  beat_cnt <= '0;
                  state    <= STREAM;
               end
            end
            STREAM: begin
               if (beat) begin
                  if (beat_cnt == IN_LAST) begin
                     beat_cnt <= '0;
                     rr_ptr   <= (grant == GW'(NUM_REQ-1)) ? '0 : grant + GW'(1);
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + BW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)      resp_cnt <= '0;
      else if (resp_hs) resp_cnt <= tag_pop ? '0 : resp_cnt + RW'(1);
   end

   // NOTE: every output gets a default before any branch, so no path leaves
   // a value held and no latch is inferred. Reset forces all outputs to 0,
   // including the pass-through data paths.
   always_comb begin
      o_req_ready  = '0;
      o_resp_valid = '0;
      o_resp_data  = '0;
      o_eng_data   = '0;
      o_eng_valid  = 1'b0;
      o_eng_ready  = 1'b0;
      o_busy       = 1'b0;
      if (!i_reset) begin
         if (state == STREAM) begin
            o_eng_valid        = i_req_valid[grant];
            o_eng_data         = req_word[grant];
            o_req_ready[grant] = i_eng_ready;
         end
         // Results are only steered while a tag names their owner.
         if (!tag_empty) begin
            o_eng_ready  = |(i_resp_ready & head_onehot);
            o_resp_valid = i_eng_valid ? head_onehot : '0;
         end
         o_resp_data = i_eng_data;
         o_busy      = (state != IDLE) | (tag_count != '0);
      end
   end

   assign o_grant = grant;

endmodule

// File: tb/tb_sparse_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sparse_mult_arbiter
//   Self-checking bench: drives two requesters and an engine stand-in that
//   returns the last word of each 11-word frame, and compares the arbiter
//   against a queue-based model of grant order, beat acceptance and result
//   steering every cycle.
// ---------------------------------------------------------------------------
module tb_sparse_mult_arbiter;
   import sparse_mult_pkg::*;

   localparam int W       = SPARSE_WIDTH;
   localparam int N       = 2;
   localparam int IN_LEN  = E_IN_LEN;
   localparam int OUT_LEN = E_OUT_LEN;
   localparam int MAX_OUT = 2;

   logic             i_clock = 1'b0;
   logic             i_reset;
   logic [N*W-1:0]   i_req_data;
   logic [N-1:0]     i_req_valid;
   logic [N-1:0]     o_req_ready;
   logic [W-1:0]     o_resp_data;
   logic [N-1:0]     o_resp_valid;
   logic [N-1:0]     i_resp_ready;
   logic [W-1:0]     o_eng_data;
   logic             o_eng_valid;
   logic             i_eng_ready;
   logic [W-1:0]     i_eng_data;
   logic             i_eng_valid;
   logic             o_eng_ready;
   logic [0:0]       o_grant;
   logic             o_busy;

   sparse_mult_arbiter #(
      .WIDTH           (W),
      .NUM_REQ         (N),
      .IN_LEN          (IN_LEN),
      .OUT_LEN         (OUT_LEN),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_req_data   (i_req_data),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .o_resp_data  (o_resp_data),
      .o_resp_valid (o_resp_valid),
      .i_resp_ready (i_resp_ready),
      .o_eng_data   (o_eng_data),
      .o_eng_valid  (o_eng_valid),
      .i_eng_ready  (i_eng_ready),
      .i_eng_data   (i_eng_data),
      .i_eng_valid  (i_eng_valid),
      .o_eng_ready  (o_eng_ready),
      .o_grant      (o_grant),
      .o_busy       (o_busy)
   );

   always #5 i_clock = ~i_clock;

   int total = 0;
   int bad   = 0;

   // Model state: owner of the open input frame (-1 = none), beats taken in
   // it, round-robin start, tags of granted frames not yet returned.
   int owner, beats, rr, last_grant, resp_beats;
   int tags[$];
   int grant_log[$];
   int deliver_log[$];
   logic [W-1:0] exp_q[$];

   // Requester drivers and engine stand-in.
   int sent[N], to_send[N], acc[N], delivered[N];
   logic [W-1:0] last_res[N];
   logic [W-1:0] eng_q[$];
   int ein;

   bit           rand_mode   = 1'b0;
   bit           rst_req     = 1'b1;
   bit           rst_at_edge = 1'b0;
   logic [N-1:0] resp_rdy_fixed = '1;
   int           idle_activity = 0;
   int           resp1_seen    = 0;

   // Word n of requester r: lane2 = r, lane1 = frame number, lane0 = beat.
   function automatic logic [W-1:0] word_of(int r, int n);
      return {32'(r), 32'(n / IN_LEN), 32'(n % IN_LEN)};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_bench();
      owner = -1; beats = 0; rr = 0; last_grant = 0; resp_beats = 0; ein = 0;
      tags.delete(); grant_log.delete(); deliver_log.delete();
      exp_q.delete(); eng_q.delete();
      for (int r = 0; r < N; r++) begin
         sent[r] = 0; to_send[r] = 0; acc[r] = 0; delivered[r] = 0; last_res[r] = '0;
      end
   endtask

   function automatic bit coin();
      return !rand_mode || ($urandom_range(3) != 0);
   endfunction

   task automatic drive();
      i_reset = rst_req;
      if (rst_req) clear_bench();
      for (int r = 0; r < N; r++) begin
         i_req_valid[r]          = (to_send[r] > 0) && coin();
         i_req_data[r*W +: W]    = word_of(r, sent[r]);
         i_resp_ready[r]         = rand_mode ? coin() : resp_rdy_fixed[r];
      end
      i_eng_ready = coin();
      i_eng_valid = (eng_q.size() > 0) && coin();
      i_eng_data  = i_eng_valid ? eng_q[0] : {3{$urandom()}};
   endtask

   task automatic check_cycle();
      logic [N-1:0] e_req_ready, e_resp_valid;
      logic         e_eng_valid, e_eng_ready, e_busy;
      logic [W-1:0] e_eng_data;
      bit           resp_hs, beat;
      int           pick, r;

      if (i_reset) begin
         if (rst_at_edge) begin
            check("rst_ctrl", W'({o_req_ready, o_resp_valid, o_eng_valid, o_eng_ready, o_busy, o_grant}), '0);
            check("rst_eng_data", o_eng_data, '0);
            check("rst_resp_data", o_resp_data, '0);
         end
         return;
      end

      e_req_ready = '0; e_resp_valid = '0; e_eng_valid = 1'b0; e_eng_data = '0; e_eng_ready = 1'b0;
      if (owner >= 0) begin
         e_eng_valid        = i_req_valid[owner];
         e_eng_data         = word_of(owner, acc[owner]);
         e_req_ready[owner] = i_eng_ready;
      end
      if (tags.size() > 0) begin
         e_eng_ready           = i_resp_ready[tags[0]];
         e_resp_valid[tags[0]] = i_eng_valid;
      end
      e_busy = (owner >= 0) || (tags.size() > 0);

      check("req_ready", W'(o_req_ready), W'(e_req_ready));
      check("eng_valid", W'(o_eng_valid), W'(e_eng_valid));
      check("eng_data", o_eng_data, e_eng_data);
      check("resp_valid", W'(o_resp_valid), W'(e_resp_valid));
      check("eng_ready", W'(o_eng_ready), W'(e_eng_ready));
      check("busy", W'(o_busy), W'(e_busy));
      check("grant", W'(o_grant), W'(last_grant));

      if (|o_resp_valid || o_eng_valid || o_busy) idle_activity++;
      if (o_resp_valid[1]) resp1_seen++;

      resp_hs = (tags.size() > 0) && i_eng_valid && i_resp_ready[tags[0]];
      beat    = (owner >= 0) && i_req_valid[owner] && i_eng_ready;
      pick    = -1;
      if (owner < 0 && tags.size() < MAX_OUT)
         for (int k = 0; k < N; k++)
            if (pick < 0 && i_req_valid[(rr + k) % N]) pick = (rr + k) % N;

      // Requester drivers follow the real handshakes.
      for (int q = 0; q < N; q++)
         if (i_req_valid[q] && o_req_ready[q]) begin
            sent[q]++;
            to_send[q]--;
         end

      // Engine stand-in: one result (the last input word) per IN_LEN inputs.
      if (o_eng_valid && i_eng_ready) begin
         ein++;
         if (ein == IN_LEN) begin
            eng_q.push_back(o_eng_data);
            ein = 0;
         end
      end
      if (i_eng_valid && o_eng_ready && eng_q.size() > 0) void'(eng_q.pop_front());

      if (resp_hs) begin
         r = tags[0];
         delivered[r]++;
         deliver_log.push_back(r);
         last_res[r] = o_resp_data;
         if (exp_q.size() == 0) check("resp_unexpected", W'(1), W'(0));
         else check("resp_data", o_resp_data, exp_q.pop_front());
         resp_beats++;
         if (resp_beats == OUT_LEN) begin
            void'(tags.pop_front());
            resp_beats = 0;
         end
      end
      if (beat) begin
         acc[owner]++;
         beats++;
         if (beats == IN_LEN) begin
            exp_q.push_back(word_of(owner, acc[owner] - 1));
            rr    = (owner + 1) % N;
            owner = -1;
            beats = 0;
         end
      end
      if (pick >= 0) begin
         owner      = pick;
         last_grant = pick;
         tags.push_back(pick);
         grant_log.push_back(pick);
      end
   endtask

   task automatic step();
      @(posedge i_clock);
      rst_at_edge = i_reset;
      #1;
      drive();
      @(negedge i_clock);
      check_cycle();
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      step();
      step();
      rst_req = 1'b0;
   endtask

   initial begin
      clear_bench();
      drive();
      do_reset();

      // 1: idle for 100 cycles
      idle_activity = 0;
      repeat (100) step();
      check("t1_idle_activity", W'(idle_activity), W'(0));

      // 2: one req0 frame, result is its word 10
      resp1_seen = 0;
      to_send[0] = IN_LEN;
      for (int c = 0; c < 300 && delivered[0] < 1; c++) step();
      repeat (20) step();
      check("t2_delivered0", W'(delivered[0]), W'(1));
      check("t2_result0", last_res[0], W'(10));
      check("t2_resp1_seen", W'(resp1_seen), W'(0));

      // 3: both requesters start together
      do_reset();
      to_send[0] = IN_LEN;
      to_send[1] = IN_LEN;
      for (int c = 0; c < 400 && (delivered[0] < 1 || delivered[1] < 1); c++) step();
      check("t3_grant_order", W'(grant_log.size() == 2 ? {grant_log[0][3:0], grant_log[1][3:0]} : 8'hff), W'(8'h01));
      check("t3_deliver_order", W'(deliver_log.size() == 2 ? {deliver_log[0][3:0], deliver_log[1][3:0]} : 8'hff), W'(8'h01));
      check("t3_result0", last_res[0], {32'd0, 32'd0, 32'd10});
      check("t3_result1", last_res[1], {32'd1, 32'd0, 32'd10});

      // 4: req0 result stalled, outstanding limit caps grants at 2
      do_reset();
      resp_rdy_fixed = 2'b10;
      to_send[0] = 2 * IN_LEN;
      to_send[1] = 2 * IN_LEN;
      repeat (150) step();
      check("t4_grants_stalled", W'(grant_log.size()), W'(2));
      check("t4_delivered_stalled", W'(delivered[0] + delivered[1]), W'(0));
      resp_rdy_fixed = 2'b11;
      for (int c = 0; c < 500 && (delivered[0] < 2 || delivered[1] < 2); c++) step();
      check("t4_grants_total", W'(grant_log.size()), W'(4));
      check("t4_deliver_order", W'(deliver_log.size() == 4 ?
            {deliver_log[0][3:0], deliver_log[1][3:0], deliver_log[2][3:0], deliver_log[3][3:0]} : 16'hffff),
            W'(16'h0101));

      // 5: random valid/ready on every port, 20 frames per requester
      do_reset();
      rand_mode = 1'b1;
      to_send[0] = 20 * IN_LEN;
      to_send[1] = 20 * IN_LEN;
      for (int c = 0; c < 20000 && (delivered[0] < 20 || delivered[1] < 20); c++) step();
      rand_mode = 1'b0;
      repeat (10) step();
      check("t5_delivered0", W'(delivered[0]), W'(20));
      check("t5_delivered1", W'(delivered[1]), W'(20));
      check("t5_accepted0", W'(acc[0]), W'(20 * IN_LEN));
      check("t5_accepted1", W'(acc[1]), W'(20 * IN_LEN));
      check("t5_sent", W'(sent[0] + sent[1]), W'(40 * IN_LEN));

      // 6: reset after 5 beats of a req1 frame
      do_reset();
      to_send[1] = IN_LEN;
      for (int c = 0; c < 100 && acc[1] < 5; c++) step();
      check("t6_beats_before_reset", W'(acc[1]), W'(5));
      do_reset();
      to_send[0] = IN_LEN;
      to_send[1] = IN_LEN;
      for (int c = 0; c < 400 && delivered[0] < 1; c++) step();
      check("t6_first_grant", W'(grant_log.size() > 0 ? grant_log[0] : 7), W'(0));
      check("t6_result0", last_res[0], {32'd0, 32'd0, 32'd10});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
